// File: rtl/tl_memory_access.sv
// MEM stage of the pipelined MIPS.
// Resolves branches, performs word loads/stores on an internal synchronous
// data memory and holds the MEM/WB pipeline register.  A read-only debug
// port lets the debug unit dump data memory.
// There is no valid/ready handshake here: i_stall is the only flow control.
// While it is high, the MEM/WB register holds, stores are suppressed and no
// branch is taken.
module tl_memory_access #(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_ADDRESS_DATA      = 7,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_stall,
  input  logic [LEN-1:0]                  i_alu_result,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic                            i_alu_zero,
  input  logic [LEN-1:0]                  i_add_execute,
  input  logic [NB_ADDRESS_DATA-1:0]      i_debug_addr,
  output logic                            o_pc_src,
  output logic [LEN-1:0]                  o_branch_dir,
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_alu_result,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic                            o_misaligned,
  output logic [LEN-1:0]                  o_debug_data
);

  localparam int DEPTH = 1 << NB_ADDRESS_DATA;

  // ctrl_mem bit positions
  localparam int CM_BRANCH = 2;
  localparam int CM_READ   = 1;
  localparam int CM_WRITE  = 0;
  // ctrl_wb bit position of reg_write
  localparam int CW_REG_WRITE = 1;

  logic [LEN-1:0]             mem [DEPTH];
  logic [NB_ADDRESS_DATA-1:0] word_index;
  logic                       misalign;
  logic                       store_en;
  logic [NB_CTRL_WB-1:0]      ctrl_wb_next;

  // Word index drops the byte offset; upper address bits wrap the memory.
  assign word_index = i_alu_result[NB_ADDRESS_DATA+1:2];

  // Any memory access that is not word aligned is flagged and neutralised.
  assign misalign = (i_ctrl_mem[CM_READ] | i_ctrl_mem[CM_WRITE]) &
                    (i_alu_result[1:0] != 2'b00);

  // A store needs a clean, unstalled, out-of-reset write request.
  assign store_en = i_ctrl_mem[CM_WRITE] & ~misalign & ~i_stall & i_rst;

  // A misaligned instruction must not write the register file.
  always_comb begin
    ctrl_wb_next = i_ctrl_wb;
    if (misalign) ctrl_wb_next[CW_REG_WRITE] = 1'b0;
  end

  // Branch resolution is combinational so IF can redirect this cycle.
  assign o_pc_src     = i_ctrl_mem[CM_BRANCH] & i_alu_zero & ~i_stall;
  assign o_branch_dir = i_add_execute;

  // Data memory write port; contents are not touched by reset.
  always_ff @(posedge i_clk) begin
    if (store_en) mem[word_index] <= i_dato2;
  end

  // MEM/WB register plus read-first load and debug reads.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_ctrl_wb    <= '0;
      o_misaligned <= 1'b0;
      o_debug_data <= '0;
    end else begin
      o_debug_data <= mem[i_debug_addr];
      if (!i_stall) begin
        o_read_data  <= mem[word_index];
        o_alu_result <= i_alu_result;
        o_write_reg  <= i_write_reg;
        o_ctrl_wb    <= ctrl_wb_next;
        o_misaligned <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_tl_memory_access.sv
// Bench for tl_memory_access: directed vector table, reset sequence and a
// randomized run against a word-array reference model.
module tb_tl_memory_access;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall;
  logic [31:0] i_alu_result;
  logic [31:0] i_dato2;
  logic [4:0]  i_write_reg;
  logic [1:0]  i_ctrl_wb;
  logic [2:0]  i_ctrl_mem;
  logic        i_alu_zero;
  logic [31:0] i_add_execute;
  logic [6:0]  i_debug_addr;
  logic        o_pc_src;
  logic [31:0] o_branch_dir;
  logic [31:0] o_read_data;
  logic [31:0] o_alu_result;
  logic [4:0]  o_write_reg;
  logic [1:0]  o_ctrl_wb;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  tl_memory_access dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
    .i_alu_result(i_alu_result), .i_dato2(i_dato2),
    .i_write_reg(i_write_reg), .i_ctrl_wb(i_ctrl_wb),
    .i_ctrl_mem(i_ctrl_mem), .i_alu_zero(i_alu_zero),
    .i_add_execute(i_add_execute), .i_debug_addr(i_debug_addr),
    .o_pc_src(o_pc_src), .o_branch_dir(o_branch_dir),
    .o_read_data(o_read_data), .o_alu_result(o_alu_result),
    .o_write_reg(o_write_reg), .o_ctrl_wb(o_ctrl_wb),
    .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- vector record ----------------
  typedef struct {
    logic        stall;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic [2:0]  cm;
    logic        zero;
    logic [31:0] addx;
    logic [6:0]  dbg;
    logic        e_pc;
    logic [31:0] e_rd;
    logic [31:0] e_alu;
    logic [4:0]  e_wr;
    logic [1:0]  e_wb;
    logic        e_mis;
    logic [31:0] e_dbg;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [128];
  logic [31:0] m_rd, m_alu, m_dbg;
  logic [4:0]  m_wr;
  logic [1:0]  m_wb;
  logic        m_mis;

  task automatic model_reset();
    m_rd = 0; m_alu = 0; m_dbg = 0; m_wr = 0; m_wb = 0; m_mis = 0;
  endtask

  // One clock edge of the MEM stage, computed from address arithmetic.
  task automatic model_step(input vec_t v);
    int  idx;
    bit  is_mem, bad;
    idx    = (v.alu / 4) % 128;
    is_mem = v.cm[1] || v.cm[0];
    bad    = is_mem && (v.alu % 4 != 0);
    m_dbg  = m_mem[v.dbg];
    if (!v.stall) begin
      m_rd  = m_mem[idx];
      m_alu = v.alu;
      m_wr  = v.wr;
      m_wb  = bad ? {1'b0, v.wb[0]} : v.wb;
      m_mis = bad;
      if (v.cm[0] && !bad) m_mem[idx] = v.d2;
    end
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    i_stall       = v.stall;
    i_alu_result  = v.alu;
    i_dato2       = v.d2;
    i_write_reg   = v.wr;
    i_ctrl_wb     = v.wb;
    i_ctrl_mem    = v.cm;
    i_alu_zero    = v.zero;
    i_add_execute = v.addx;
    i_debug_addr  = v.dbg;
  endtask

  // Apply one vector for one cycle; expectations come from the table record
  // (use_table) or from the reference model.
  task automatic run_vec(input string tag, input vec_t v, input bit use_table, input bit do_check);
    logic exp_pc;
    @(negedge i_clk);
    drive(v);
    #1;
    exp_pc = use_table ? v.e_pc : (v.cm[2] & v.zero & ~v.stall);
    if (do_check) begin
      chk({tag, "_pc_src"}, {31'd0, o_pc_src}, {31'd0, exp_pc});
      chk({tag, "_branch_dir"}, o_branch_dir, v.addx);
    end
    @(posedge i_clk);
    model_step(v);
    #1;
    if (do_check) begin
      chk({tag, "_read_data"}, o_read_data, use_table ? v.e_rd : m_rd);
      chk({tag, "_alu_result"}, o_alu_result, use_table ? v.e_alu : m_alu);
      chk({tag, "_write_reg"}, {27'd0, o_write_reg}, {27'd0, use_table ? v.e_wr : m_wr});
      chk({tag, "_ctrl_wb"}, {30'd0, o_ctrl_wb}, {30'd0, use_table ? v.e_wb : m_wb});
      chk({tag, "_misaligned"}, {31'd0, o_misaligned}, {31'd0, use_table ? v.e_mis : m_mis});
      chk({tag, "_debug_data"}, o_debug_data, use_table ? v.e_dbg : m_dbg);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_read_data"}, o_read_data, 32'd0);
    chk({tag, "_alu_result"}, o_alu_result, 32'd0);
    chk({tag, "_write_reg"}, {27'd0, o_write_reg}, 32'd0);
    chk({tag, "_ctrl_wb"}, {30'd0, o_ctrl_wb}, 32'd0);
    chk({tag, "_misaligned"}, {31'd0, o_misaligned}, 32'd0);
    chk({tag, "_debug_data"}, o_debug_data, 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t tbl [16];
  vec_t v;

  initial begin
    // Directed table (memory word i preloaded with 0x1000_0000 + i).
    //          stall alu          d2           wr  wb     cm      z  addx   dbg  pc rd            alu          wr  wb     mis dbg
    tbl[0]  = '{0, 32'h10,  32'hDEADBEEF, 5'd0, 2'b00, 3'b001, 0, 32'h0,  7'd4, 0, 32'h10000004, 32'h10,  5'd0, 2'b00, 0, 32'h10000004};
    tbl[1]  = '{0, 32'h10,  32'h0,        5'd7, 2'b11, 3'b010, 0, 32'h0,  7'd4, 0, 32'hDEADBEEF, 32'h10,  5'd7, 2'b11, 0, 32'hDEADBEEF};
    tbl[2]  = '{0, 32'h0,   32'h0,        5'd0, 2'b00, 3'b100, 1, 32'h40, 7'd0, 1, 32'h10000000, 32'h0,   5'd0, 2'b00, 0, 32'h10000000};
    tbl[3]  = '{0, 32'h4,   32'h0,        5'd0, 2'b00, 3'b100, 0, 32'h40, 7'd1, 0, 32'h10000001, 32'h4,   5'd0, 2'b00, 0, 32'h10000001};
    tbl[4]  = '{1, 32'h8,   32'h0,        5'd3, 2'b11, 3'b100, 1, 32'h40, 7'd2, 0, 32'h10000001, 32'h4,   5'd0, 2'b00, 0, 32'h10000002};
    tbl[5]  = '{0, 32'h12,  32'h1,        5'd9, 2'b11, 3'b001, 0, 32'h0,  7'd4, 0, 32'hDEADBEEF, 32'h12,  5'd9, 2'b01, 1, 32'hDEADBEEF};
    tbl[6]  = '{0, 32'h10,  32'h0,        5'd9, 2'b11, 3'b010, 0, 32'h0,  7'd4, 0, 32'hDEADBEEF, 32'h10,  5'd9, 2'b11, 0, 32'hDEADBEEF};
    tbl[7]  = '{0, 32'h11,  32'h0,        5'd10,2'b11, 3'b010, 0, 32'h0,  7'd4, 0, 32'hDEADBEEF, 32'h11,  5'd10,2'b01, 1, 32'hDEADBEEF};
    tbl[8]  = '{0, 32'h200, 32'h55,       5'd0, 2'b00, 3'b001, 0, 32'h0,  7'd0, 0, 32'h10000000, 32'h200, 5'd0, 2'b00, 0, 32'h10000000};
    tbl[9]  = '{0, 32'h0,   32'h0,        5'd0, 2'b00, 3'b000, 0, 32'h0,  7'd0, 0, 32'h55,       32'h0,   5'd0, 2'b00, 0, 32'h55};
    tbl[10] = '{0, 32'h0,   32'hAA,       5'd2, 2'b11, 3'b011, 0, 32'h0,  7'd0, 0, 32'h55,       32'h0,   5'd2, 2'b11, 0, 32'h55};
    tbl[11] = '{0, 32'h0,   32'h0,        5'd2, 2'b11, 3'b010, 0, 32'h0,  7'd0, 0, 32'hAA,       32'h0,   5'd2, 2'b11, 0, 32'hAA};
    tbl[12] = '{1, 32'h8,   32'h12345678, 5'd5, 2'b10, 3'b001, 0, 32'h0,  7'd2, 0, 32'hAA,       32'h0,   5'd2, 2'b11, 0, 32'h10000002};
    tbl[13] = '{0, 32'h8,   32'h0,        5'd5, 2'b10, 3'b010, 0, 32'h0,  7'd2, 0, 32'h10000002, 32'h8,   5'd5, 2'b10, 0, 32'h10000002};
    tbl[14] = '{0, 32'h9,   32'h0,        5'd6, 2'b11, 3'b010, 0, 32'h0,  7'd3, 0, 32'h10000002, 32'h9,   5'd6, 2'b01, 1, 32'h10000003};
    tbl[15] = '{1, 32'h20,  32'h0,        5'd1, 2'b11, 3'b000, 0, 32'h0,  7'd8, 0, 32'h10000002, 32'h9,   5'd6, 2'b01, 1, 32'h10000008};

    // Reset state.
    i_rst = 1'b0;
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_regs_zero("reset_init");
    @(negedge i_clk);
    i_rst = 1'b1;

    // Preload every word with a known pattern.
    for (int i = 0; i < 128; i++) begin
      v = '{0, i * 4, 32'h10000000 + i, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_vec("preload", v, 1'b0, 1'b0);
    end

    // Directed table.
    for (int i = 0; i < 16; i++) run_vec($sformatf("tbl%0d", i), tbl[i], 1'b1, 1'b1);

    // Mid-cycle asynchronous reset while reg_write traffic is flowing.
    v = '{0, 32'h30, 32'h0, 5'd4, 2'b11, 3'b010, 0, 32'h0, 7'd12, 0, 0, 0, 0, 0, 0, 0};
    run_vec("pre_rst", v, 1'b0, 1'b1);
    @(negedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk_regs_zero("rst_async");
    model_reset();
    // A store presented during reset must not land.
    v = '{0, 32'h14, 32'h00000BAD, 5'd4, 2'b11, 3'b001, 0, 32'h0, 7'd5, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    @(posedge i_clk);
    #1;
    chk_regs_zero("rst_hold");
    @(negedge i_clk);
    i_rst = 1'b1;
    i_ctrl_mem = 3'b000;
    v = '{0, 32'h14, 32'h0, 5'd8, 2'b11, 3'b010, 0, 32'h0, 7'd5, 0, 0, 0, 0, 0, 0, 0};
    run_vec("post_rst", v, 1'b0, 1'b1);
    chk("rst_no_store", o_read_data, 32'h10000005);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v.stall = ($urandom_range(0, 4) == 0);
      v.alu   = {22'd0, $urandom_range(0, 1023)};
      if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
      v.d2    = $urandom;
      v.wr    = $urandom_range(0, 31);
      v.wb    = $urandom_range(0, 3);
      v.cm    = $urandom_range(0, 7);
      v.zero  = $urandom_range(0, 1);
      v.addx  = $urandom;
      v.dbg   = $urandom_range(0, 127);
      run_vec($sformatf("rnd%0d", i), v, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
